alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one 2-stage pipelined ALU (operands registered, result registered) among N_REQ
//  requesters via round-robin arbitration, one issue per cycle.
//  Drives the ALU's ctrl/in0/in1 ports and aligns ctrl with the operand register stage.
//  Returns each result to its issuer using an in-flight tag pipeline.
//  Sits between the per-core instruction decoders and the shared ALU instance.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width; must match the ALU
//  N_REQ       4   number of requesters, 2..8
//  IDX_W       $clog2(N_REQ)  requester index width (localparam, not overridable)
// PORTS
//  clk        in   1               system clock
//  rstn       in   1               asynchronous reset, active low
//  hold       in   1               1 = grant nothing this cycle (in-flight ops still complete)
//  req_valid  in   N_REQ           per-requester op valid
//  req_ready  out  N_REQ           per-requester accept; a transfer occurs when valid & ready
//  req_ctrl   in   3*N_REQ         packed ALU opcode, requester i at [3i+2:3i]
//  req_in0    in   DATA_WIDTH*N_REQ  packed operand 0
//  req_in1    in   DATA_WIDTH*N_REQ  packed operand 1
//  alu_ctrl   out  3               to ALU ctrl
//  alu_in0    out  DATA_WIDTH      to ALU in0
//  alu_in1    out  DATA_WIDTH      to ALU in1
//  alu_out    in   DATA_WIDTH      from ALU out
//  rsp_valid  out  N_REQ           one-hot, 1-cycle pulse: result for requester i is on rsp_data
//  rsp_data   out  DATA_WIDTH      result, shared by all requesters
//  busy       out  1               any op in flight or granted this cycle
// BEHAVIOUR
//  Reset (rstn=0, async): rr_ptr=0, tag pipeline cleared, alu_ctrl=0, alu_in0=alu_in1=0,
//   rsp_valid=0, rsp_data=0, busy=0. req_ready=0 during reset.
//  Arbitration (combinational):
//   - req_ready is one-hot or zero.
//   - If hold=0, grant the first i with req_valid[i] set, searching rr_ptr, rr_ptr+1, ...
//     modulo N_REQ (wrap from N_REQ-1 back to 0).
//   - req_ready depends on req_valid only through the grant; hold=1 -> req_ready=0.
//  On grant of i at cycle T:
//   - rr_ptr <= (i+1) mod N_REQ; rr_ptr is unchanged when nothing is granted.
//   - alu_in0/alu_in1 are driven combinationally with requester i's operands in T
//     (the ALU registers them at the T edge).
//  ctrl alignment:
//   - alu_ctrl is a register loaded with req_ctrl[i] at the T edge, valid during T+1.
//   - When nothing is granted, alu_ctrl holds its value; operands are don't-care but
//     driven to 0.
//  Tag pipeline:
//   - 2 stages of {valid, IDX_W idx}; stage0 <= grant, stage1 <= stage0.
//   - ALU result for the issue at T appears on alu_out during T+2.
//   - rsp_valid[idx]/rsp_data are registered from stage1 & alu_out, asserted in T+3.
//   - Total latency: accept at T -> rsp_valid in T+3.
//   - rsp_data holds its last value when rsp_valid=0.
//  Throughput: back-to-back issues from any mix of requesters, 1 op/cycle.
//   - The same requester may have up to 3 ops in flight.
//   - Responses return in issue order; there is no response backpressure, so
//     requesters must always accept results.
//  busy = |req_ready | stage0.valid | stage1.valid.
//  Opcodes are passed through unchecked; 3'd7 yields result 0 from the ALU and is
//   still tagged and returned.
//  Simultaneous events:
//   - hold asserted with ops in flight: no new grants, pipeline drains normally.
//   - A requester dropping req_valid while not granted loses nothing.
//  Reset mid-operation: all in-flight tags are discarded, so no rsp_valid appears for
//   ops accepted before reset; rr_ptr returns to 0.
// TESTING
//  1. Single requester 0: ctrl=1, in0=5, in1=7 accepted at T -> rsp_valid=4'b0001,
//     rsp_data=12 at T+3; busy high T..T+2.
//  2. All 4 valid continuously for 8 cycles from reset -> grants 0,1,2,3,0,1,2,3;
//     results return in the same order, one per cycle.
//  3. Requester 2 streams ctrl=2 (sub), in0=3, in1=5 for 3 consecutive cycles ->
//     three pulses on rsp_valid[2] with rsp_data=32'hFFFF_FFFE.
//  4. Grant to 3, then only 1 and 3 valid -> next grant 1 (wrap via rr_ptr=0), then 3.
//  5. hold=1 with requester 1 valid -> req_ready=0; release hold -> granted.
//     In-flight op from before hold still returns at T+3.
//  6. Issue ops at T and T+1, pulse rstn low at T+2 -> no rsp_valid ever;
//     rr_ptr=0, all outputs at reset values.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin sharing of one 2-stage pipelined ALU among N_REQ
//               requesters, with a tag pipeline that routes results back.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        hold,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [3*N_REQ-1:0]          req_ctrl,
    input  logic [DATA_WIDTH*N_REQ-1:0] req_in0,
    input  logic [DATA_WIDTH*N_REQ-1:0] req_in1,
    output logic [2:0]                  alu_ctrl,
    output logic [DATA_WIDTH-1:0]       alu_in0,
    output logic [DATA_WIDTH-1:0]       alu_in1,
    input  logic [DATA_WIDTH-1:0]       alu_out,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic                        busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int SUM_W = IDX_W + 1;

    logic [2:0]            w_ctrl [N_REQ];
    logic [DATA_WIDTH-1:0] w_in0  [N_REQ];
    logic [DATA_WIDTH-1:0] w_in1  [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_ctrl[gi] = req_ctrl[3*gi +: 3];
            assign w_in0[gi]  = req_in0[DATA_WIDTH*gi +: DATA_WIDTH];
            assign w_in1[gi]  = req_in1[DATA_WIDTH*gi +: DATA_WIDTH];
        end
    endgenerate

    logic [IDX_W-1:0] r_rr_ptr;
    logic [2:0]       r_alu_ctrl;
    logic             r_s0_vld;
    logic [IDX_W-1:0] r_s0_idx;
    logic             r_s1_vld;
    logic [IDX_W-1:0] r_s1_idx;
    logic [N_REQ-1:0] r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    logic             w_grant_vld;
    logic [IDX_W-1:0] w_grant_idx;
    logic [SUM_W-1:0] w_sum;
    logic [N_REQ-1:0] w_ready;
    logic [IDX_W-1:0] w_ptr_next;

    // Search from r_rr_ptr upward, wrapping modulo N_REQ (which need not be a power of 2).
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        if (rstn && !hold) begin
            for (int k = 0; k < N_REQ; k++) begin
                w_sum = {1'b0, r_rr_ptr} + SUM_W'(k);
                if (w_sum >= SUM_W'(N_REQ)) begin
                    w_sum = w_sum - SUM_W'(N_REQ);
                end
                if (!w_grant_vld && req_valid[w_sum[IDX_W-1:0]]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = w_sum[IDX_W-1:0];
                end
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_grant_vld) begin
            w_ready[w_grant_idx] = 1'b1;
        end
    end

    assign w_ptr_next = (w_grant_idx == IDX_W'(N_REQ - 1)) ? '0 : w_grant_idx + IDX_W'(1);

    assign req_ready = w_ready;
    assign alu_in0   = w_grant_vld ? w_in0[w_grant_idx] : '0;
    assign alu_in1   = w_grant_vld ? w_in1[w_grant_idx] : '0;
    assign alu_ctrl  = r_alu_ctrl;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = (|w_ready) | r_s0_vld | r_s1_vld;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr    <= '0;
            r_alu_ctrl  <= '0;
            r_s0_vld    <= 1'b0;
            r_s0_idx    <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_idx    <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            if (w_grant_vld) begin
                r_rr_ptr   <= w_ptr_next;
                r_alu_ctrl <= w_ctrl[w_grant_idx];
            end
            r_s0_vld <= w_grant_vld;
            r_s0_idx <= w_grant_idx;
            r_s1_vld <= r_s0_vld;
            r_s1_idx <= r_s0_idx;
            // Stage 1 lines up with the ALU result register output.
            r_rsp_valid <= '0;
            if (r_s1_vld) begin
                r_rsp_valid[r_s1_idx] <= 1'b1;
                r_rsp_data            <= alu_out;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Scoreboard bench for alu_arbiter with a 2-stage ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rstn;
    logic            hold;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [3*NR-1:0] req_ctrl;
    logic [DW*NR-1:0] req_in0;
    logic [DW*NR-1:0] req_in1;
    logic [2:0]      alu_ctrl;
    logic [DW-1:0]   alu_in0;
    logic [DW-1:0]   alu_in1;
    logic [DW-1:0]   alu_out;
    logic [NR-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            busy;

    alu_arbiter #(.DATA_WIDTH(DW), .N_REQ(NR)) dut (
        .clk(clk), .rstn(rstn), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ctrl(req_ctrl), .req_in0(req_in0), .req_in1(req_in1),
        .alu_ctrl(alu_ctrl), .alu_in0(alu_in0), .alu_in1(alu_in1),
        .alu_out(alu_out), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    // ALU model: operands registered, result registered.
    logic [DW-1:0] alu_a = '0, alu_b = '0, alu_res = '0;
    always @(posedge clk) begin
        alu_a   <= alu_in0;
        alu_b   <= alu_in1;
        alu_res <= alu_f(alu_ctrl, alu_a, alu_b);
    end
    assign alu_out = alu_res;

    logic [2:0]    opc [NR];
    logic [DW-1:0] opa [NR];
    logic [DW-1:0] opb [NR];
    always_comb begin
        req_ctrl = '0;
        req_in0  = '0;
        req_in1  = '0;
        for (int i = 0; i < NR; i++) begin
            req_ctrl[3*i +: 3]  = opc[i];
            req_in0[DW*i +: DW] = opa[i];
            req_in1[DW*i +: DW] = opb[i];
        end
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response appears.
    always @(negedge clk) begin
        if (rstn) begin
            if (rsp_valid != '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected actual_valid=%b actual_data=%h expected=none", rsp_valid, rsp_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (rsp_valid !== NR'(1 << e.idx) || rsp_data !== e.data || cyc_cnt != e.cyc) begin
                        errors++;
                        $display("FAIL rsp actual valid=%b data=%h cyc=%0d expected valid=%b data=%h cyc=%0d",
                                 rsp_valid, rsp_data, cyc_cnt, NR'(1 << e.idx), e.data, e.cyc);
                    end
                end
            end else if (sb.size() > 0 && cyc_cnt >= sb[0].cyc) begin
                exp_t e;
                checks++;
                errors++;
                e = sb.pop_front();
                $display("FAIL rsp_missing actual=none expected idx=%0d data=%h cyc=%0d", e.idx, e.data, e.cyc);
            end
        end
    end

    task automatic step(input logic [NR-1:0] vld, input logic hld, input logic [NR-1:0] exp_rdy, input logic exp_busy);
        int idx;
        req_valid = vld;
        hold      = hld;
        @(negedge clk);
        chk("req_ready", DW'(req_ready), DW'(exp_rdy));
        chk("busy", DW'(busy), DW'(exp_busy));
        if (exp_rdy != '0) begin
            idx = 0;
            for (int i = 0; i < NR; i++) if (exp_rdy[i]) idx = i;
            chk("alu_in0", alu_in0, opa[idx]);
            chk("alu_in1", alu_in1, opb[idx]);
            sb.push_back('{idx, alu_f(opc[idx], opa[idx], opb[idx]), cyc_cnt + 3});
        end else begin
            chk("alu_in0_idle", alu_in0, '0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        step('0, 1'b0, '0, 1'b1);
        step('0, 1'b0, '0, 1'b1);
        step('0, 1'b0, '0, 1'b0);
    endtask

    task automatic check_reset();
        chk("rst_req_ready", DW'(req_ready), '0);
        chk("rst_alu_ctrl", DW'(alu_ctrl), '0);
        chk("rst_alu_in0", alu_in0, '0);
        chk("rst_alu_in1", alu_in1, '0);
        chk("rst_rsp_valid", DW'(rsp_valid), '0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_busy", DW'(busy), '0);
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        hold      = 1'b0;
        req_valid = '1;
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        sb.delete();
        req_valid = '0;
        rstn      = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        hold = 1'b0;
        req_valid = '0;
        for (int i = 0; i < NR; i++) begin
            opc[i] = '0;
            opa[i] = '0;
            opb[i] = '0;
        end
        do_reset();

        // Single requester 0: 5 + 7
        opc[0] = 3'd1; opa[0] = 32'd5; opb[0] = 32'd7;
        step(4'b0001, 1'b0, 4'b0001, 1'b1);
        drain();
        @(negedge clk);
        chk("rsp_data_hold", rsp_data, 32'd12);
        chk("rsp_valid_pulse", DW'(rsp_valid), '0);
        @(posedge clk);
        #1;

        // All four valid from reset: strict rotation
        do_reset();
        opc[0] = 3'd1; opa[0] = 32'd10;        opb[0] = 32'd20;
        opc[1] = 3'd2; opa[1] = 32'd100;       opb[1] = 32'd1;
        opc[2] = 3'd3; opa[2] = 32'h0000_F0F0; opb[2] = 32'h0000_FF00;
        opc[3] = 3'd5; opa[3] = 32'hAAAA_0000; opb[3] = 32'h5555_00FF;
        for (int r = 0; r < 2; r++) begin
            step(4'hF, 1'b0, 4'b0001, 1'b1);
            step(4'hF, 1'b0, 4'b0010, 1'b1);
            step(4'hF, 1'b0, 4'b0100, 1'b1);
            step(4'hF, 1'b0, 4'b1000, 1'b1);
        end
        drain();

        // Requester 2 streams 3 - 5
        opc[2] = 3'd2; opa[2] = 32'd3; opb[2] = 32'd5;
        repeat (3) step(4'b0100, 1'b0, 4'b0100, 1'b1);
        drain();

        // Wrap: grant 3, then 1 and 3 valid -> 1, then 3; opcode 7 yields 0
        opc[3] = 3'd7; opa[3] = 32'd9; opb[3] = 32'd9;
        opc[1] = 3'd4; opa[1] = 32'h0F; opb[1] = 32'hF0;
        step(4'b1000, 1'b0, 4'b1000, 1'b1);
        step(4'b1010, 1'b0, 4'b0010, 1'b1);
        step(4'b1010, 1'b0, 4'b1000, 1'b1);
        drain();

        // Hold with an op in flight
        opc[0] = 3'd1; opa[0] = 32'hFFFF_FFFF; opb[0] = 32'd2;
        step(4'b0001, 1'b0, 4'b0001, 1'b1);
        step(4'b0010, 1'b1, 4'b0000, 1'b1);
        step(4'b0010, 1'b1, 4'b0000, 1'b1);
        step(4'b0010, 1'b0, 4'b0010, 1'b1);
        drain();
        step(4'b0010, 1'b1, 4'b0000, 1'b0);

        // Reset mid-operation discards in-flight tags and rr_ptr
        step(4'b0100, 1'b0, 4'b0100, 1'b1);
        step(4'b0001, 1'b0, 4'b0001, 1'b1);
        do_reset();
        repeat (4) step('0, 1'b0, '0, 1'b0);
        step(4'hF, 1'b0, 4'b0001, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", DW'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
